// File: rtl/serdes_shift_reg.sv
// serdes_shift_reg: multi-lane double-buffered PISO/SIPO shift register with load handshake and gap-free frames
module serdes_shift_reg #(
  parameter int WIDTH     = 24,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [LANES*WIDTH-1:0] load_data_i,
  input  logic                   load_valid_i,
  output logic                   load_ready_o,
  input  logic                   shift_en_i,
  input  logic [LANES-1:0]       serial_in_i,
  output logic [LANES-1:0]       serial_out_o,
  output logic [LANES*WIDTH-1:0] q_o,
  output logic [LANES-1:0]       carry_o,
  output logic                   busy_o,
  output logic                   done_o
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e                 state_q, state_d;
  logic [LANES*WIDTH-1:0] sreg_q, sreg_d, hold_q, hold_d, shifted;
  logic                   hold_full_q, hold_full_d, done_q, done_d;
  logic [LANES-1:0]       carry_q, carry_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   last;
  for (genvar k = 0; k < LANES; k++) begin : g_lane
    logic [WIDTH-1:0] seg;
    assign seg = sreg_q[k*WIDTH +: WIDTH];
    assign shifted[k*WIDTH +: WIDTH] = MSB_FIRST ? {seg[WIDTH-2:0], serial_in_i[k]}
                                                 : {serial_in_i[k], seg[WIDTH-1:1]};
    assign serial_out_o[k] = MSB_FIRST ? seg[WIDTH-1] : seg[0];
  end
  assign last         = shift_en_i && (cnt_q == CW'(WIDTH - 1));
  assign load_ready_o = !hold_full_q;
  assign busy_o       = state_q == SHIFT;
  assign q_o          = sreg_q;
  assign carry_o      = carry_q;
  assign done_o       = done_q;
  always_comb begin
    state_d     = state_q;
    sreg_d      = sreg_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    if (load_valid_i && !hold_full_q) begin
      hold_d      = load_data_i;
      hold_full_d = 1'b1;
    end
    if (state_q == IDLE) begin
      if (hold_full_q) begin
        sreg_d      = hold_q;
        hold_full_d = 1'b0;
        cnt_d       = '0;
        carry_d     = '0;
        state_d     = SHIFT;
      end
    end else if (shift_en_i) begin
      sreg_d  = shifted;
      carry_d = serial_out_o;
      cnt_d   = cnt_q + 1'b1;
      // On the last bit a waiting word replaces the frame on the same edge; Carry keeps the final bit
      if (last) begin
        done_d = 1'b1;
        if (hold_full_q) begin
          sreg_d      = hold_q;
          hold_full_d = 1'b0;
          cnt_d       = '0;
        end else begin
          state_d = IDLE;
        end
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      carry_q     <= '0;
      cnt_q       <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      done_q      <= done_d;
    end
  end
endmodule

// File: tb/tb_serdes_shift_reg.sv
// tb_serdes_shift_reg: vector table, directed corner sequences and random traffic vs. a frame-level model
module tb_serdes_shift_reg;
  logic        clk = 1'b0, rst = 1'b0;
  logic [15:0] load_data = '0;
  logic        load_valid = 1'b0, shift_en = 1'b0, loop = 1'b0;
  logic [1:0]  sin_v = '0;
  logic [1:0]  serial_in, serial_out, carry;
  logic [15:0] q;
  logic        load_ready, busy, done;
  logic [7:0]  r_data = '0, r_q;
  logic        r_valid = 1'b0, r_en = 1'b0, r_sin = 1'b0;
  logic        r_ready, r_sout, r_carry, r_busy, r_done;
  int n_cmp = 0, n_err = 0;
  always #5 clk = ~clk;
  assign serial_in = loop ? serial_out : sin_v;
  serdes_shift_reg #(.WIDTH(8), .LANES(2), .MSB_FIRST(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .load_data_i(load_data), .load_valid_i(load_valid),
    .load_ready_o(load_ready), .shift_en_i(shift_en), .serial_in_i(serial_in),
    .serial_out_o(serial_out), .q_o(q), .carry_o(carry), .busy_o(busy), .done_o(done));
  serdes_shift_reg #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b0)) dut_r (
    .clk_i(clk), .rst_i(rst), .load_data_i(r_data), .load_valid_i(r_valid),
    .load_ready_o(r_ready), .shift_en_i(r_en), .serial_in_i(r_sin),
    .serial_out_o(r_sout), .q_o(r_q), .carry_o(r_carry), .busy_o(r_busy), .done_o(r_done));
  // frame-level model of the 2-lane MSB-first instance
  int          m_reg[2], m_carry[2], m_pos;
  logic [15:0] m_hold;
  bit          m_hf, m_act, m_done;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic step(input bit r, input bit v, input logic [15:0] d, input bit e, input logic [1:0] s);
    bit acc, nd;
    int o, si;
    rst = r; load_valid = v; load_data = d; shift_en = e; sin_v = s;
    @(posedge clk); #1;
    if (r) begin
      m_reg = '{0, 0}; m_carry = '{0, 0}; m_pos = 0; m_hold = '0;
      m_hf = 0; m_act = 0; m_done = 0;
    end else begin
      acc = v && !m_hf;
      nd = 0;
      if (!m_act) begin
        if (m_hf) begin
          m_reg[0] = int'(m_hold[7:0]); m_reg[1] = int'(m_hold[15:8]);
          m_carry = '{0, 0}; m_hf = 0; m_pos = 0; m_act = 1;
        end
      end else if (e) begin
        for (int l = 0; l < 2; l++) begin
          o = (m_reg[l] >> 7) & 1;
          si = loop ? o : int'(s[l]);
          m_carry[l] = o;
          m_reg[l] = ((m_reg[l] << 1) | si) & 255;
        end
        m_pos++;
        if (m_pos == 8) begin
          nd = 1;
          if (m_hf) begin
            m_reg[0] = int'(m_hold[7:0]); m_reg[1] = int'(m_hold[15:8]);
            m_hf = 0; m_pos = 0;
          end else m_act = 0;
        end
      end
      if (acc) begin m_hold = d; m_hf = 1; end
      m_done = nd;
    end
    chk("q", 32'(q), {16'h0, 8'(m_reg[1]), 8'(m_reg[0])});
    chk("serial_out", 32'(serial_out), 32'(((m_reg[1] >> 7) & 1) * 2 + ((m_reg[0] >> 7) & 1)));
    chk("carry", 32'(carry), 32'(m_carry[1] * 2 + m_carry[0]));
    chk("busy", 32'(busy), 32'(m_act));
    chk("done", 32'(done), 32'(m_done));
    chk("load_ready", 32'(load_ready), 32'(!m_hf));
  endtask
  typedef struct {bit v; bit e; logic [1:0] sout; bit busy; bit done; bit ready;} vec_t;
  vec_t        tbl[11];
  logic [15:0] bits;
  logic [7:0]  bits8;
  int          n_done, en_cnt;
  bit          seen;
  initial begin
    tbl[0]  = '{1, 0, 2'b00, 0, 0, 0};
    tbl[1]  = '{0, 0, 2'b01, 1, 0, 1};
    tbl[2]  = '{0, 1, 2'b00, 1, 0, 1};
    tbl[3]  = '{0, 1, 2'b11, 1, 0, 1};
    tbl[4]  = '{0, 1, 2'b10, 1, 0, 1};
    tbl[5]  = '{0, 1, 2'b10, 1, 0, 1};
    tbl[6]  = '{0, 1, 2'b11, 1, 0, 1};
    tbl[7]  = '{0, 1, 2'b00, 1, 0, 1};
    tbl[8]  = '{0, 1, 2'b01, 1, 0, 1};
    tbl[9]  = '{0, 1, 2'b00, 0, 1, 1};
    tbl[10] = '{0, 0, 2'b00, 0, 0, 1};
    step(1, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    chk("reset_r_busy", 32'(r_busy), 0);
    chk("reset_r_ready", 32'(r_ready), 1);
    // lane0 = A5, lane1 = 3C, MSB first
    for (int i = 0; i < 11; i++) begin
      step(0, tbl[i].v, 16'h3CA5, tbl[i].e, 2'b00);
      chk($sformatf("tbl%0d_sout", i), 32'(serial_out), 32'(tbl[i].sout));
      chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
      chk($sformatf("tbl%0d_done", i), 32'(done), 32'(tbl[i].done));
      chk($sformatf("tbl%0d_ready", i), 32'(load_ready), 32'(tbl[i].ready));
    end
    // loopback recirculates the frame back into Q
    loop = 1'b1;
    step(0, 1, 16'h5AC3, 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1, 0);
    chk("loop_q", 32'(q), 32'h5AC3);
    loop = 1'b0;
    step(0, 0, '0, 0, 0);
    // LSB-first instance
    r_valid = 1'b1; r_data = 8'h01;
    step(0, 0, '0, 0, 0);
    r_valid = 1'b0;
    step(0, 0, '0, 0, 0);
    chk("lsb_busy", 32'(r_busy), 1);
    chk("lsb_first_bit", 32'(r_sout), 1);
    r_en = 1'b1;
    for (int j = 1; j < 8; j++) begin
      step(0, 0, '0, 0, 0);
      chk($sformatf("lsb_bit%0d", j), 32'(r_sout), 0);
      if (j == 1) chk("lsb_carry", 32'(r_carry), 1);
    end
    step(0, 0, '0, 0, 0);
    chk("lsb_done", 32'(r_done), 1);
    chk("lsb_busy_end", 32'(r_busy), 0);
    r_en = 1'b0;
    step(0, 0, '0, 0, 0);
    chk("lsb_done_pulse", 32'(r_done), 0);
    // back-to-back frames: second word accepted while shifting bit 3
    step(0, 1, 16'hAB12, 0, 0);
    step(0, 0, '0, 0, 0);
    bits = '0; n_done = 0;
    for (int c = 0; c < 16; c++) begin
      bits = {bits[14:0], serial_out[0]};
      step(0, c == 3, 16'hCD34, 1, 0);
      if (done) n_done++;
      if (c < 15) chk($sformatf("b2b_busy%0d", c), 32'(busy), 1);
      if (c >= 3 && c < 7) chk($sformatf("b2b_ready%0d", c), 32'(load_ready), 0);
      if (c == 7) chk("b2b_ready_xfer", 32'(load_ready), 1);
    end
    chk("b2b_bits", 32'(bits), 32'h1234);
    chk("b2b_done_cnt", 32'(n_done), 2);
    chk("b2b_idle", 32'(busy), 0);
    step(0, 0, '0, 0, 0);
    // random stalls over an F0 frame
    step(0, 1, 16'h00F0, 0, 0);
    step(0, 0, '0, 0, 0);
    bits8 = '0; en_cnt = 0; seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin
      bit e;
      e = (c < 4) ? bit'((4'b1001 >> c) & 1) : bit'($urandom_range(0, 1));
      if (e && busy) begin bits8 = {bits8[6:0], serial_out[0]}; en_cnt++; end
      step(0, 0, '0, e, 0);
      if (done) seen = 1;
    end
    chk("stall_done_seen", 32'(seen), 1);
    chk("stall_en_cnt", 32'(en_cnt), 8);
    chk("stall_bits", 32'(bits8), 32'hF0);
    step(0, 0, '0, 0, 0);
    // reset mid-frame with the hold buffer full
    step(0, 1, 16'hFFFF, 0, 0);
    step(0, 0, '0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, i == 2, 16'h1122, 1, 0);
    chk("abort_hold_full", 32'(load_ready), 0);
    step(1, 0, '0, 1, 0);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_ready", 32'(load_ready), 1);
    chk("abort_done", 32'(done), 0);
    chk("abort_q", 32'(q), 0);
    step(0, 0, '0, 1, 0);
    chk("abort_no_xfer", 32'(busy), 0);
    chk("abort_no_done", 32'(done), 0);
    // random traffic with a two-cycle reset in the middle
    for (int i = 0; i < 300; i++) begin
      step(i == 150 || i == 151, $urandom_range(0, 3) == 0, 16'($urandom),
           $urandom_range(0, 3) != 0, 2'($urandom));
      if (i == 152) begin
        chk("rnd_rst_q", 32'(q), 0);
        chk("rnd_rst_carry", 32'(carry), 0);
        chk("rnd_rst_done", 32'(done), 0);
      end
      if (i == 151) begin
        chk("rnd_rst_busy", 32'(busy), 0);
        chk("rnd_rst_ready", 32'(load_ready), 1);
        chk("rnd_rst_q0", 32'(q), 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
